// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared types for the AXI-Lite master slice.
//   resp_t      : AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   mst_state_t : master transaction FSM states
//   WDOG_W      : watchdog counter width (covers TIMEOUT up to 65535)
// -----------------------------------------------------------------------------
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'd0,
      EXOKAY = 2'd1,
      SLVERR = 2'd2,
      DECERR = 2'd3
   } resp_t;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_REQ  = 3'd1,
      WR_RESP = 3'd2,
      RD_REQ  = 3'd3,
      RD_DATA = 3'd4,
      RESP    = 3'd5
   } mst_state_t;

   localparam int WDOG_W = 16;

endpackage

// File: rtl/axi_lite_wdog.sv
// -----------------------------------------------------------------------------
// axi_lite_wdog
// Per-transaction cycle counter. Counts while enable is high and saturates at
// TIMEOUT; expired stays high from then until the next clear.
// Ports:
//   clk, rstn : clock, synchronous active-low reset
//   clear     : restart the count (new transaction accepted)
//   enable    : count this cycle
//   expired   : count has reached TIMEOUT
// -----------------------------------------------------------------------------
module axi_lite_wdog
   import axi_lite_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rstn,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [WDOG_W-1:0] count_q;
   logic [WDOG_W-1:0] count_d;

   assign expired = (count_q >= WDOG_W'(TIMEOUT));

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !expired) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// Single-outstanding AXI-Lite master driven by a simple command/response
// handshake. A watchdog aborts any transaction that stalls for TIMEOUT cycles
// and reports DECERR (2'b11) locally without finishing the bus handshake.
// Ports:
//   clk, rstn                       : clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_write,
//   cmd_addr, cmd_wdata, cmd_wstrb  : command side (one at a time)
//   rsp_valid/rsp_ready, rsp_rdata,
//   rsp_resp                        : response side
//   m_aw*, m_w*, m_b*, m_ar*, m_r*  : AXI-Lite master channels (registered)
// -----------------------------------------------------------------------------
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic [ADDR_W-1:0]   m_awaddr,
   output logic                m_awvalid,
   input  logic                m_awready,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wstrb,
   output logic                m_wvalid,
   input  logic                m_wready,
   input  logic [1:0]          m_bresp,
   input  logic                m_bvalid,
   output logic                m_bready,
   output logic [ADDR_W-1:0]   m_araddr,
   output logic                m_arvalid,
   input  logic                m_arready,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic [1:0]          m_rresp,
   input  logic                m_rvalid,
   output logic                m_rready
);

   mst_state_t          state_q;
   logic [ADDR_W-1:0]   m_awaddr_q;
   logic [ADDR_W-1:0]   m_araddr_q;
   logic [DATA_W-1:0]   m_wdata_q;
   logic [DATA_W/8-1:0] m_wstrb_q;
   logic                m_awvalid_q;
   logic                m_wvalid_q;
   logic                m_bready_q;
   logic                m_arvalid_q;
   logic                m_rready_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [1:0]          rsp_resp_q;

   logic accept;
   logic busy;
   logic aw_done;
   logic w_done;
   logic completing;
   logic wdog_expired;
   logic abort;

   assign cmd_ready = (state_q == IDLE) && rstn;
   assign accept    = cmd_valid && cmd_ready;
   assign busy      = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                      (state_q == RD_REQ) || (state_q == RD_DATA);

   // A channel is done once its valid has dropped or it handshakes this cycle,
   // so AW and W may complete in either order or together.
   assign aw_done = !m_awvalid_q || m_awready;
   assign w_done  = !m_wvalid_q  || m_wready;

   // A phase that completes this cycle wins over a simultaneous timeout.
   always_comb begin
      completing = 1'b0;
      case (state_q)
         WR_REQ:  completing = aw_done && w_done;
         WR_RESP: completing = m_bvalid;
         RD_REQ:  completing = m_arready;
         RD_DATA: completing = m_rvalid;
         default: completing = 1'b0;
      endcase
   end

   assign abort = busy && wdog_expired && !completing;

   axi_lite_wdog #(
      .TIMEOUT(TIMEOUT)
   ) u_wdog (
      .clk    (clk),
      .rstn   (rstn),
      .clear  (accept),
      .enable (busy),
      .expired(wdog_expired)
   );

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         m_awaddr_q  <= '0;
         m_araddr_q  <= '0;
         m_wdata_q   <= '0;
         m_wstrb_q   <= '0;
         m_awvalid_q <= 1'b0;
         m_wvalid_q  <= 1'b0;
         m_bready_q  <= 1'b0;
         m_arvalid_q <= 1'b0;
         m_rready_q  <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  m_wdata_q <= cmd_wdata;
                  m_wstrb_q <= cmd_wstrb;
                  if (cmd_write) begin
                     m_awaddr_q  <= cmd_addr;
                     m_awvalid_q <= 1'b1;
                     m_wvalid_q  <= 1'b1;
                     state_q     <= WR_REQ;
                  end else begin
                     m_araddr_q  <= cmd_addr;
                     m_arvalid_q <= 1'b1;
                     state_q     <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (m_awvalid_q && m_awready) m_awvalid_q <= 1'b0;
               if (m_wvalid_q && m_wready)   m_wvalid_q  <= 1'b0;
               if (aw_done && w_done) begin
                  m_bready_q <= 1'b1;
                  state_q    <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (m_bvalid) begin
                  m_bready_q  <= 1'b0;
                  rsp_resp_q  <= m_bresp;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RD_REQ: begin
               if (m_arready) begin
                  m_arvalid_q <= 1'b0;
                  m_rready_q  <= 1'b1;
                  state_q     <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (m_rvalid) begin
                  m_rready_q  <= 1'b0;
                  rsp_resp_q  <= m_rresp;
                  rsp_rdata_q <= m_rdata;
                  rsp_valid_q <= 1'b1;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Local abort: walk away from the bus without finishing handshakes,
         // so anything the slave sends afterwards is simply never accepted.
         if (abort) begin
            m_awvalid_q <= 1'b0;
            m_wvalid_q  <= 1'b0;
            m_bready_q  <= 1'b0;
            m_arvalid_q <= 1'b0;
            m_rready_q  <= 1'b0;
            rsp_resp_q  <= DECERR;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
         end
      end
   end

   assign m_awaddr  = m_awaddr_q;
   assign m_awvalid = m_awvalid_q;
   assign m_wdata   = m_wdata_q;
   assign m_wstrb   = m_wstrb_q;
   assign m_wvalid  = m_wvalid_q;
   assign m_bready  = m_bready_q;
   assign m_araddr  = m_araddr_q;
   assign m_arvalid = m_arvalid_q;
   assign m_rready  = m_rready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
// Directed bench: a small CSR-like slave model for normal traffic, and a
// manually driven stub slave for stall, ordering, timeout and reset cases.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic [3:0]    cmd_wstrb = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [AW-1:0] m_awaddr;
   logic          m_awvalid, m_awready;
   logic [DW-1:0] m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_wvalid, m_wready;
   logic [1:0]    m_bresp;
   logic          m_bvalid, m_bready;
   logic [AW-1:0] m_araddr;
   logic          m_arvalid, m_arready;
   logic [DW-1:0] m_rdata;
   logic [1:0]    m_rresp;
   logic          m_rvalid, m_rready;

   always #5 clk = ~clk;

   axi_lite_master #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(TO)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_write(cmd_write),
      .cmd_addr (cmd_addr),
      .cmd_wdata(cmd_wdata),
      .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_resp (rsp_resp),
      .m_awaddr (m_awaddr),
      .m_awvalid(m_awvalid),
      .m_awready(m_awready),
      .m_wdata  (m_wdata),
      .m_wstrb  (m_wstrb),
      .m_wvalid (m_wvalid),
      .m_wready (m_wready),
      .m_bresp  (m_bresp),
      .m_bvalid (m_bvalid),
      .m_bready (m_bready),
      .m_araddr (m_araddr),
      .m_arvalid(m_arvalid),
      .m_arready(m_arready),
      .m_rdata  (m_rdata),
      .m_rresp  (m_rresp),
      .m_rvalid (m_rvalid),
      .m_rready (m_rready)
   );

   // ---------------- slave: CSR model or manual stub ----------------
   logic          manual = 1'b0;
   logic          man_awready = 1'b0, man_wready = 1'b0, man_bvalid = 1'b0;
   logic          man_arready = 1'b0, man_rvalid = 1'b0;
   logic [1:0]    man_bresp = '0, man_rresp = '0;
   logic [DW-1:0] man_rdata = '0;

   logic          s_aw_got = 1'b0, s_w_got = 1'b0, s_bvalid = 1'b0, s_rvalid = 1'b0;
   logic [AW-1:0] s_awaddr = '0;
   logic [DW-1:0] s_wdata = '0, s_rdata = '0;
   logic [3:0]    s_wstrb = '0;
   logic [DW-1:0] mem [0:255];
   int            aw_hs = 0, w_hs = 0;

   assign m_awready = manual ? man_awready : (!s_aw_got && !s_bvalid);
   assign m_wready  = manual ? man_wready  : (!s_w_got && !s_bvalid);
   assign m_bvalid  = manual ? man_bvalid  : s_bvalid;
   assign m_bresp   = manual ? man_bresp   : 2'd0;
   assign m_arready = manual ? man_arready : !s_rvalid;
   assign m_rvalid  = manual ? man_rvalid  : s_rvalid;
   assign m_rdata   = manual ? man_rdata   : s_rdata;
   assign m_rresp   = manual ? man_rresp   : 2'd0;

   always @(posedge clk) begin
      if (m_awvalid && m_awready) aw_hs <= aw_hs + 1;
      if (m_wvalid && m_wready)   w_hs  <= w_hs + 1;
      if (!rstn || manual) begin
         s_aw_got <= 1'b0;
         s_w_got  <= 1'b0;
         s_bvalid <= 1'b0;
         s_rvalid <= 1'b0;
      end else begin
         if (m_awvalid && m_awready) begin
            s_aw_got <= 1'b1;
            s_awaddr <= m_awaddr;
         end
         if (m_wvalid && m_wready) begin
            s_w_got <= 1'b1;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
         end
         if (s_aw_got && s_w_got) begin
            for (int b = 0; b < 4; b++)
               if (s_wstrb[b]) mem[s_awaddr][8*b +: 8] <= s_wdata[8*b +: 8];
            s_aw_got <= 1'b0;
            s_w_got  <= 1'b0;
            s_bvalid <= 1'b1;
         end
         if (s_bvalid && m_bready) s_bvalid <= 1'b0;
         if (m_arvalid && m_arready) begin
            s_rvalid <= 1'b1;
            s_rdata  <= mem[m_araddr];
         end
         if (s_rvalid && m_rready) s_rvalid <= 1'b0;
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge right
   // after the acceptance edge.
   task automatic send_cmd(input logic wr, input logic [7:0] addr,
                           input logic [31:0] wd, input logic [3:0] ws);
      int n;
      n = 0;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      cmd_wstrb = ws;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("cmd_accepted", 32'(n < 50), 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // lat = number of clock edges after acceptance until rsp_valid is seen.
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("rsp_arrived", 32'(rsp_valid), 32'd1);
      $display("txn addr=0x%02h write=%0d resp=%0d rdata=0x%08h latency=%0d",
               cmd_addr, cmd_write, rsp_resp, rsp_rdata, lat);
   endtask

   task automatic finish_rsp();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench stalled");
   end

   initial begin
      int lat;
      int bad_valid, bad_data, bad_ready, late_rsp;
      int aw0, w0;

      // ---- reset state ----
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_awvalid",   32'(m_awvalid), 32'd0);
      check("rst_arvalid",   32'(m_arvalid), 32'd0);
      check("rst_bready",    32'(m_bready),  32'd0);
      check("rst_rsp_resp",  32'(rsp_resp),  32'd0);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

      // ---- write then read back through CSR model ----
      send_cmd(1'b1, 8'h02, 32'h0000_00A5, 4'hF);
      wait_rsp(lat);
      check("wr_resp",    32'(rsp_resp), 32'd0);
      check("wr_rdata",   rsp_rdata,     32'd0);
      check("wr_latency", 32'(lat),      32'd3);
      finish_rsp();

      send_cmd(1'b0, 8'h02, 32'h0, 4'h0);
      wait_rsp(lat);
      check("rd_byte",    32'(rsp_rdata[7:0]), 32'h0000_00A5);
      check("rd_resp",    32'(rsp_resp),       32'd0);
      check("rd_latency", 32'(lat),            32'd2);
      finish_rsp();

      // ---- partial strobes ----
      send_cmd(1'b1, 8'h10, 32'h1122_3344, 4'hF);
      wait_rsp(lat);
      finish_rsp();
      send_cmd(1'b1, 8'h10, 32'hAABB_CCDD, 4'h5);
      wait_rsp(lat);
      finish_rsp();
      send_cmd(1'b0, 8'h10, 32'h0, 4'h0);
      wait_rsp(lat);
      check("strobe_merge", rsp_rdata, 32'h11BB_33DD);
      finish_rsp();

      // ---- response back-pressure ----
      send_cmd(1'b0, 8'h10, 32'h0, 4'h0);
      wait_rsp(lat);
      bad_valid = 0; bad_data = 0; bad_ready = 0;
      repeat (10) begin
         @(negedge clk);
         if (!rsp_valid) bad_valid++;
         if (rsp_rdata !== 32'h11BB_33DD) bad_data++;
         if (cmd_ready) bad_ready++;
      end
      check("hold_valid_drops", 32'(bad_valid), 32'd0);
      check("hold_data_changes", 32'(bad_data), 32'd0);
      check("hold_cmd_ready", 32'(bad_ready), 32'd0);
      finish_rsp();
      check("post_hs_cmd_ready", 32'(cmd_ready), 32'd1);
      check("post_hs_rsp_valid", 32'(rsp_valid), 32'd0);
      cmd_write = 1'b0; cmd_addr = 8'h02; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("next_accept_arvalid", 32'(m_arvalid), 32'd1);
      check("next_accept_araddr",  32'(m_araddr),  32'h02);
      wait_rsp(lat);
      check("next_rd_byte", 32'(rsp_rdata[7:0]), 32'h0000_00A5);
      finish_rsp();

      // ---- W handshake 3 cycles before AW ----
      manual = 1'b1;
      aw0 = aw_hs; w0 = w_hs;
      send_cmd(1'b1, 8'h33, 32'hDEAD_BEEF, 4'h9);
      check("ord_awvalid_up", 32'(m_awvalid), 32'd1);
      check("ord_wvalid_up",  32'(m_wvalid),  32'd1);
      check("ord_wdata",      m_wdata,        32'hDEAD_BEEF);
      check("ord_wstrb",      32'(m_wstrb),   32'h9);
      man_wready = 1'b1;
      @(negedge clk);
      man_wready = 1'b0;
      check("ord_w_dropped",  32'(m_wvalid),  32'd0);
      check("ord_aw_still",   32'(m_awvalid), 32'd1);
      repeat (2) @(negedge clk);
      check("ord_awaddr_held", 32'(m_awaddr), 32'h33);
      check("ord_bready_early", 32'(m_bready), 32'd0);
      man_awready = 1'b1;
      @(negedge clk);
      man_awready = 1'b0;
      check("ord_bready_up",   32'(m_bready),  32'd1);
      check("ord_aw_dropped",  32'(m_awvalid), 32'd0);
      check("ord_aw_hs_count", 32'(aw_hs - aw0), 32'd1);
      check("ord_w_hs_count",  32'(w_hs - w0),   32'd1);
      man_bresp = 2'd2; man_bvalid = 1'b1;
      @(negedge clk);
      man_bvalid = 1'b0;
      check("ord_rsp_valid", 32'(rsp_valid), 32'd1);
      check("ord_rsp_resp",  32'(rsp_resp),  32'd2);
      check("ord_rsp_rdata", rsp_rdata,      32'd0);
      check("ord_bready_dn", 32'(m_bready),  32'd0);
      finish_rsp();

      // ---- write timeout with AW never ready ----
      send_cmd(1'b1, 8'h44, 32'h0000_0001, 4'h1);
      wait_rsp(lat);
      check("to_wr_latency", 32'(lat),       32'd17);
      check("to_wr_resp",    32'(rsp_resp),  32'd3);
      check("to_wr_rdata",   rsp_rdata,      32'd0);
      check("to_awvalid",    32'(m_awvalid), 32'd0);
      check("to_wvalid",     32'(m_wvalid),  32'd0);
      man_bresp = 2'd0; man_bvalid = 1'b1;
      repeat (2) @(negedge clk);
      check("to_late_b_resp",  32'(rsp_resp), 32'd3);
      check("to_late_b_ready", 32'(m_bready), 32'd0);
      finish_rsp();
      man_bvalid = 1'b0;
      check("to_idle_again", 32'(cmd_ready), 32'd1);

      // ---- read timeout with AR never ready ----
      send_cmd(1'b0, 8'h55, 32'h0, 4'h0);
      wait_rsp(lat);
      check("to_rd_latency", 32'(lat),       32'd17);
      check("to_rd_resp",    32'(rsp_resp),  32'd3);
      check("to_arvalid",    32'(m_arvalid), 32'd0);
      finish_rsp();

      // ---- read data arriving in the expiry cycle wins ----
      send_cmd(1'b0, 8'h77, 32'h0, 4'h0);
      man_arready = 1'b1;
      @(negedge clk);
      man_arready = 1'b0;
      repeat (15) @(negedge clk);
      check("tie_no_rsp_yet", 32'(rsp_valid), 32'd0);
      check("tie_rready",     32'(m_rready),  32'd1);
      man_rdata = 32'h1234_5678; man_rresp = 2'd1; man_rvalid = 1'b1;
      @(negedge clk);
      man_rvalid = 1'b0;
      check("tie_rsp_valid", 32'(rsp_valid), 32'd1);
      check("tie_rsp_resp",  32'(rsp_resp),  32'd1);
      check("tie_rsp_rdata", rsp_rdata,      32'h1234_5678);
      finish_rsp();

      // ---- reset while waiting in WR_RESP ----
      man_awready = 1'b1; man_wready = 1'b1;
      aw0 = aw_hs;
      send_cmd(1'b1, 8'h66, 32'hCAFE_F00D, 4'hF);
      @(negedge clk);
      man_awready = 1'b0; man_wready = 1'b0;
      check("mid_bready", 32'(m_bready), 32'd1);
      rstn = 1'b0;
      @(negedge clk);
      check("mid_rst_bready",   32'(m_bready),  32'd0);
      check("mid_rst_awvalid",  32'(m_awvalid), 32'd0);
      check("mid_rst_rsp",      32'(rsp_valid), 32'd0);
      check("mid_rst_awaddr",   32'(m_awaddr),  32'd0);
      check("mid_rst_araddr",   32'(m_araddr),  32'd0);
      check("mid_rst_wdata",    m_wdata,        32'd0);
      check("mid_rst_wstrb",    32'(m_wstrb),   32'd0);
      check("mid_rst_rdata",    rsp_rdata,      32'd0);
      rstn = 1'b1;
      #1;
      check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
      man_bresp = 2'd0; man_bvalid = 1'b1;
      late_rsp = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) late_rsp++;
      end
      man_bvalid = 1'b0;
      check("mid_rst_no_rsp", 32'(late_rsp), 32'd0);
      check("mid_rst_aw_hs",  32'(aw_hs - aw0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
